// File: rtl/clk_meas_pkg.sv
// Shared constants for clock-measurement blocks: FSM encodings and synchronizer depth.
package clk_meas_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit multi-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous signal over back-to-back gate windows of clk cycles.
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic synced, synced_d, edge_now;

    sync_2ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sig_in),
        .q    (synced)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced_d <= 1'b0;
        end else begin
            synced_d <= synced;
        end
    end

    assign edge_now = synced & ~synced_d;

    logic [0:0]        state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic             hit_max;
    logic [CNT_W-1:0] edge_sum;

    // An edge arriving while the counter is already full is lost, which is what marks overflow.
    assign hit_max  = edge_now & (edge_q == CNT_MAX);
    assign edge_sum = hit_max ? edge_q : edge_q + CNT_W'(edge_now);

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                gate_d = '0;
                edge_d = '0;
                sat_d  = 1'b0;
                if (enable) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // Close and restart in one cycle so no edge falls between windows.
                    count_d = edge_sum;
                    ovf_d   = sat_q | hit_max;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = edge_sum;
                    sat_d  = sat_q | hit_max;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: two instances (CNT_W=8 and CNT_W=4), GATE_CYCLES=100.
module tb_clk_freq_meter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       enable4;
    logic       sig_in;
    logic [7:0] count;
    logic       valid, overflow, busy;
    logic [3:0] count4;
    logic       valid4, overflow4, busy4;

    int n_cmp = 0;
    int n_bad = 0;
    int period = 10;
    int ph = 0;

    clk_freq_meter #(
        .GATE_CYCLES(100),
        .CNT_W      (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .sig_in  (sig_in),
        .count   (count),
        .valid   (valid),
        .overflow(overflow),
        .busy    (busy)
    );

    clk_freq_meter #(
        .GATE_CYCLES(100),
        .CNT_W      (4)
    ) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable4),
        .sig_in  (sig_in),
        .count   (count4),
        .valid   (valid4),
        .overflow(overflow4),
        .busy    (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Measured signal: square wave of `period` clk cycles, held low when period is 0.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (period == 0) begin
                ph = 0;
                sig_in = 1'b0;
            end else begin
                ph = (ph + 1 >= period) ? 0 : ph + 1;
                sig_in = (ph < period / 2);
            end
        end
    end

    task automatic wait_valid(input bit sel, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if ((sel ? valid4 : valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sig_in == 1'b0) break;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        enable4 = 1'b0;
        period = 10;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({count, valid, overflow, busy} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got count=%0d valid=%b ovf=%b busy=%b, want all 0",
                     count, valid, overflow, busy);
        end
        release_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy, valid);
        end
    endtask

    task automatic test_steady();
        int cyc;
        bit ok;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || cyc != 100) begin
            n_bad++;
            $display("FAIL first_window_len: got ok=%b cyc=%0d want 100", ok, cyc);
        end
        n_cmp++;
        if (count !== 8'd10 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL steady_count: got %0d ovf=%b want 10 ovf=0", count, overflow);
        end
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_pulse_width: got %b want 0", valid);
        end
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || cyc != 99 || count !== 8'd10) begin
            n_bad++;
            $display("FAIL steady_period: got ok=%b cyc=%0d count=%0d want 99+1 count=10",
                     ok, cyc, count);
        end
    endtask

    task automatic test_fast();
        int cyc;
        bit ok;
        period = 4;
        wait_valid(1'b0, cyc, ok);
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || cyc != 100 || count !== 8'd25 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fast_count: got ok=%b cyc=%0d count=%0d ovf=%b want 100 25 0",
                     ok, cyc, count, overflow);
        end
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || count !== 8'd25) begin
            n_bad++;
            $display("FAIL fast_count2: got ok=%b count=%0d want 25", ok, count);
        end
    endtask

    task automatic test_static();
        int cyc;
        bit ok;
        period = 0;
        wait_valid(1'b0, cyc, ok);
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || count !== 8'd0 || busy !== 1'b1 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL static_count: got ok=%b count=%0d busy=%b ovf=%b want 0 1 0",
                     ok, count, busy, overflow);
        end
    endtask

    task automatic test_abort();
        int cyc;
        int seen;
        bit ok;
        period = 10;
        wait_valid(1'b0, cyc, ok);
        wait_valid(1'b0, cyc, ok);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || count !== 8'd10) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b count=%0d want 0 10", busy, count);
        end
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0 || count !== 8'd10) begin
            n_bad++;
            $display("FAIL abort_no_valid: got %0d valids count=%0d want 0 10", seen, count);
        end
        enable = 1'b1;
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || cyc != 101 || count !== 8'd10) begin
            n_bad++;
            $display("FAIL restart_latency: got ok=%b cyc=%0d count=%0d want 101 10",
                     ok, cyc, count);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        bit ok;
        period = 4;
        repeat (10) @(negedge clk);
        enable4 = 1'b1;
        wait_valid(1'b1, cyc, ok);
        n_cmp++;
        if (!ok || cyc != 101 || count4 !== 4'd15 || overflow4 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_count: got ok=%b cyc=%0d count=%0d ovf=%b want 101 15 1",
                     ok, cyc, count4, overflow4);
        end
        period = 20;
        wait_valid(1'b1, cyc, ok);
        wait_valid(1'b1, cyc, ok);
        n_cmp++;
        if (!ok || count4 !== 4'd5 || overflow4 !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_recover: got ok=%b count=%0d ovf=%b want 5 0",
                     ok, count4, overflow4);
        end
        enable4 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        period = 10;
        wait_valid(1'b0, cyc, ok);
        wait_valid(1'b0, cyc, ok);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({count, valid, overflow, busy} !== 11'd0 || count4 !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got count=%0d valid=%b ovf=%b busy=%b count4=%0d want 0",
                     count, valid, overflow, busy, count4);
        end
        repeat (5) @(negedge clk);
        release_reset();
        wait_valid(1'b0, cyc, ok);
        n_cmp++;
        if (!ok || cyc != 101 || count !== 8'd10 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_recover: got ok=%b cyc=%0d count=%0d ovf=%b want 101 10 0",
                     ok, cyc, count, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_fast();
        test_static();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
